// File: rtl/adc_reader_pkg.sv
// Shared definitions for the serial ADC reader: FSM encoding and default frame geometry.
package adc_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_QUIET   = 2'd2
  } state_t;

  localparam int DEF_DATA_BITS    = 12;
  localparam int DEF_LEAD_BITS    = 4;
  localparam int DEF_QUIET_CYCLES = 4;

endpackage

// File: rtl/adc_reader_if.sv
// Sample stream from the ADC reader to its consumer (valid/ready handshake).
interface adc_reader_if
  import adc_reader_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/adc_reader.sv
// Serial ADC frame reader: drives chip select, shifts in leading zeros plus result,
// and presents each result on a valid/ready stream with sticky overrun/frame error flags.
module adc_reader
  import adc_reader_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int LEAD_BITS    = DEF_LEAD_BITS,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
  parameter bit TWOS         = 1'b1
) (
  input  logic              clk48,
  input  logic              reset,
  input  logic              enable,
  output logic              adc_clk,
  output logic              adc_cs,
  input  logic              adc_sdo,
  adc_reader_if.master      smp,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clear_flags
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int QCNT_W     = 4;
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [QCNT_W-1:0] QUIET_LOAD = QCNT_W'(QUIET_CYCLES - 1);

  function automatic logic [DATA_BITS-1:0] fmt_sample(input logic [DATA_BITS-1:0] raw);
    logic [DATA_BITS-1:0] res;
    res = raw;
    if (TWOS) res[DATA_BITS-1] = ~raw[DATA_BITS-1];
    return res;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  // The final frame bit is taken straight from the pin on the load edge.
  logic [FRAME_BITS-2:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [QCNT_W-1:0]      r_quiet_cnt;
  logic                   r_cs;
  logic [DATA_BITS-1:0]   r_sample;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_frame_err;

  logic [FRAME_BITS-1:0]  w_frame;
  logic                   w_last;
  logic                   w_consume;
  logic                   w_lead_err;

  assign w_frame    = {r_shift, adc_sdo};
  assign w_last     = (r_state == ST_CONVERT) && (r_bit_cnt == LAST_BIT);
  assign w_consume  = r_valid && smp.sample_ready;
  assign w_lead_err = |w_frame[FRAME_BITS-1 -: LEAD_BITS];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (enable) w_state_nxt = ST_CONVERT;
      ST_CONVERT: if (w_last) w_state_nxt = ST_QUIET;
      ST_QUIET:   if (r_quiet_cnt == '0) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      r_cs        <= 1'b1;
      r_bit_cnt   <= '0;
      r_quiet_cnt <= '0;
      r_shift     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cs <= ~enable;
          if (enable) r_bit_cnt <= '0;
        end
        ST_CONVERT: begin
          r_shift   <= w_frame[FRAME_BITS-2:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last) begin
            r_cs        <= 1'b1;
            r_quiet_cnt <= QUIET_LOAD;
          end
        end
        ST_QUIET: begin
          r_cs <= 1'b1;
          if (r_quiet_cnt != '0) r_quiet_cnt <= r_quiet_cnt - 1'b1;
        end
        default: r_cs <= 1'b1;
      endcase
    end
  end

  // A load on the consuming edge refills the slot, so it is not an overrun.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_last) begin
        r_sample <= fmt_sample(w_frame[DATA_BITS-1:0]);
        r_valid  <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end

      if (w_last && r_valid && !smp.sample_ready) r_overrun <= 1'b1;
      else if (clear_flags)                       r_overrun <= 1'b0;

      if (w_last && w_lead_err) r_frame_err <= 1'b1;
      else if (clear_flags)     r_frame_err <= 1'b0;
    end
  end

  assign adc_clk          = clk48;
  assign adc_cs           = r_cs;
  assign smp.sample       = r_sample;
  assign smp.sample_valid = r_valid;
  assign overrun          = r_overrun;
  assign frame_err        = r_frame_err;

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 Parameter DATA_BITS, 12, converter result width.
REQ-002 Parameter LEAD_BITS, 4, leading zero bits per frame preceding data; frame length FRAME_BITS = LEAD_BITS + DATA_BITS (16).
REQ-003 Parameter QUIET_CYCLES, 4, minimum adc_cs-high cycles between frames (range 1..15).
REQ-004 Parameter TWOS, 1, 1 = output two's complement (invert result MSB); 0 = raw offset binary.
REQ-005 clk48  input  1  sole clock; adc_clk is clk48 passed through at top level; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = run conversions back-to-back.
REQ-008 adc_cs  output  1  converter chip select, active low, registered.
REQ-009 adc_sdo  input  1  converter serial data, MSB first.
REQ-010 sample  output  DATA_BITS  latest result, registered.
REQ-011 sample_valid  output  1  sample holds unconsumed data.
REQ-012 sample_ready  input  1  downstream (correlator feed) accepts sample this cycle.
REQ-013 overrun  output  1  sticky: an unconsumed sample was overwritten.
REQ-014 frame_err  output  1  sticky: a leading bit was read as 1.
REQ-015 clear_flags  input  1  one-cycle pulse clears overrun and frame_err.

Function
REQ-016 FSM states IDLE, CONVERT, QUIET; reset state IDLE.
REQ-017 IDLE: enable=1 at an edge -> adc_cs<=0, bit_cnt<=0, state CONVERT; else stay, adc_cs=1.
REQ-018 CONVERT: each posedge shifts adc_sdo into a FRAME_BITS shift register and increments bit_cnt; exactly FRAME_BITS captures per frame, first capture on the first edge with adc_cs already low.
REQ-019 On the edge of capture FRAME_BITS-1 (bit_cnt=15): adc_cs<=1, quiet_cnt<=QUIET_CYCLES-1, state QUIET, sample<=low DATA_BITS of {shift, adc_sdo} (MSB inverted when TWOS=1), sample_valid<=1.
REQ-020 Same edge: if any of the LEAD_BITS leading captured bits is 1, frame_err<=1; sample still updated.
REQ-021 QUIET: decrement quiet_cnt; at 0 go to IDLE; adc_cs stays 1 throughout.
REQ-022 Frame period with enable held 1 = FRAME_BITS + QUIET_CYCLES + 1 cycles (21 at defaults; adc_cs low exactly 16 cycles).
REQ-023 enable deasserted mid-frame: frame completes and result is delivered; then rests in IDLE.
REQ-024 Handshake: consumption occurs on an edge with sample_valid=1 and sample_ready=1; sample_valid<=0 unless a new result loads on that edge.
REQ-025 New result while sample_valid=1 and no consumption on that edge: sample overwritten, sample_valid stays 1, overrun<=1.
REQ-026 New result on the same edge as consumption: new data loaded, sample_valid stays 1, no overrun.
REQ-027 sample_ready while sample_valid=0 has no effect.
REQ-028 clear_flags clears both sticky flags; if a set condition occurs on the same edge, set wins.

Reset
REQ-029 Asynchronous reset forces immediately: adc_cs=1, state IDLE, sample=0, sample_valid=0, overrun=0, frame_err=0, bit_cnt=0, quiet_cnt=0, shift register=0.
REQ-030 Reset mid-frame discards the partial frame; after release, the first frame starts at the first edge with enable=1 and no result is produced from pre-reset bits.

Structure
REQ-031 Shared package holds FSM state encoding and the default constants DATA_BITS, LEAD_BITS, QUIET_CYCLES.
REQ-032 Single module; no sub-module needed (shift register and counters are inline).

Verification
REQ-033 Converter model returning 0x0ABC (offset binary), TWOS=1, enable held -> sample=0x2BC, sample_valid rises on the edge adc_cs rises, adc_cs low 16 cycles, period 21 cycles.
REQ-034 sample_ready held 1, 10 frames of ramp 0x000..0x009 -> 10 valid pulses of 1 cycle each, values in order, overrun=0.
REQ-035 sample_ready held 0 across 2 frames -> second value replaces first, overrun=1; clear_flags pulse -> overrun=0.
REQ-036 Model drives leading bits 0b0100 with data 0x123, TWOS=0 -> sample=0x123, frame_err=1 until clear_flags.
REQ-037 Assert reset at bit_cnt=7 -> adc_cs=1 and all outputs 0 before next edge; release with enable=1 -> clean frame, correct value, no spurious valid.
REQ-038 Drop enable at bit_cnt=3 -> frame completes, one sample delivered, adc_cs remains 1 afterwards.
